// File: rtl/rf_wb_queue_pkg.sv
// Shared defaults and entry layout for the writeback queue in front of the
// register file write port.
package rf_wb_queue_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    // Register 0 is hardwired; writes to it are consumed but never buffered.
    localparam int REG_ZERO  = 0;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_match.sv
// Youngest-match bypass lookup over the valid window of the writeback queue.
module rf_wb_match
    import rf_wb_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic [AW-1:0] addr_mem [DEPTH],
    input  logic [DW-1:0] data_mem [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  logic [AW-1:0] q_addr,
    output logic          hit,
    output logic [DW-1:0] hdata
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit   = 1'b0;
        hdata = '0;
        idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == q_addr) &&
                (q_addr != AW'(REG_ZERO))) begin
                hit   = 1'b1;
                hdata = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// In-order write buffer feeding the register file write port, with bypass
// lookups so decode can see buffered but not yet committed values.
module rf_wb_queue
    import rf_wb_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_addr,
    input  logic [DW-1:0]             in_data,
    input  logic                      wb_busy,
    output logic                      rf_wr,
    output logic [AW-1:0]             rf_addr,
    output logic [DW-1:0]             rf_data,
    input  logic [AW-1:0]             q_addr1,
    input  logic [AW-1:0]             q_addr2,
    output logic                      hit1,
    output logic [DW-1:0]             hdata1,
    output logic                      hit2,
    output logic [DW-1:0]             hdata2,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          enq;
    logic          deq;

    // in_ready comes only from state, so upstream never sees a path from wb_busy.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign enq      = in_valid && in_ready && (in_addr != AW'(REG_ZERO));
    assign rf_wr    = !empty && !wb_busy;
    assign deq      = rf_wr;
    assign rf_addr  = empty ? '0 : addr_mem[head];
    assign rf_data  = empty ? '0 : data_mem[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    rf_wb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match1 (
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .head     (head),
        .count    (count),
        .q_addr   (q_addr1),
        .hit      (hit1),
        .hdata    (hdata1)
    );

    rf_wb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match2 (
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .head     (head),
        .count    (count),
        .q_addr   (q_addr2),
        .hit      (hit2),
        .hdata    (hdata2)
    );

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
Writeback-side write buffer in front of the pipeline register file's single write port. Accepts register write requests from the writeback/load-completion path through a valid/ready handshake and buffers them in a small in-order FIFO. Drains one entry per cycle into the register file write port whenever the port is free. Provides a youngest-match bypass lookup on two read addresses so decode sees buffered, not-yet-committed values.

Parameters:
DEPTH, 4, number of buffered write entries (power of two, >= 2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  write request valid
in_ready  output  1  queue can accept a request this cycle
in_addr  input  AW  destination register of request
in_data  input  DW  data of request
wb_busy  input  1  write port owned by another source this cycle; hold head
rf_wr  output  1  write enable to register file write port
rf_addr  output  AW  write address to register file
rf_data  output  DW  write data to register file
q_addr1  input  AW  bypass lookup address, read port 1
q_addr2  input  AW  bypass lookup address, read port 2
hit1  output  1  q_addr1 matches a buffered entry
hdata1  output  DW  data of youngest matching entry for q_addr1
hit2  output  1  q_addr2 matches a buffered entry
hdata2  output  DW  data of youngest matching entry for q_addr2
count  output  clog2(DEPTH)+1  number of buffered entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Storage: DEPTH entries {addr, data}, head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, separate count register.
- Reset (reset low, asynchronous): head = tail = count = 0; all buffered entries dropped. Outputs immediately: rf_wr 0, in_ready 1, empty 1, full 0, hit1/hit2 0, count 0. rf_addr, rf_data, hdata1 and hdata2 are driven 0 while empty or on a miss.
- in_ready = !full. Depends only on state; no combinational path from wb_busy or in_valid.
- Enqueue: on posedge when in_valid && in_ready && in_addr != 0, write {in_addr, in_data} at tail and tail <= tail + 1.
- Address 0 requests complete the handshake (consumed) but are never stored.
- Drain: rf_wr = !empty && !wb_busy (combinational from state and wb_busy). rf_addr/rf_data = head entry. On posedge with rf_wr high, head <= head + 1. The register file commits on the following negedge.
- Latency: a request accepted at posedge t appears at the head no earlier than the cycle after t. With an empty queue and wb_busy low it drives rf_wr during cycle t..t+1.
- Simultaneous enqueue and drain in the same cycle: count unchanged.
- Full: in_ready is 0 even if a drain occurs that cycle, so the queue never overflows.
- Drain while empty is impossible because rf_wr is 0.
- wb_busy held high: the head is frozen indefinitely and no entries are lost.
- Ordering: strictly FIFO; multiple writes to the same register commit in arrival order.
- Bypass: combinational over valid entries only (those from head up to tail-1, modulo DEPTH).
  - hitN = 1 if any valid entry has addr == q_addrN and q_addrN != 0.
  - hdataN = data of the youngest (closest to tail) matching entry.
  - The request currently on in_* is not visible to bypass until it has been stored.
  - An entry draining this cycle still counts as a hit this cycle.
- count is always in the range 0..DEPTH. full and empty are derived from count.

Decomposition:
- Shared package: AW/DW defaults, DEPTH default, entry struct {addr, data}, constant for register 0.
- One natural sub-module, rf_wb_match: given the entry array, head and count, plus one query address, it returns hit and youngest data. Instantiate it twice, once per read port.

Test Plan:
- Reset, then in_valid with r5=0x1111_1111 and wb_busy=0: in_ready=1, and the next cycle shows rf_wr=1, rf_addr=5, rf_data=0x11111111; count returns to 0.
- Hold wb_busy=1 and push r1..r4 = 0xA1..0xA4: full=1 and in_ready=0 after 4 accepts. A fifth push of r6 is not taken. Release wb_busy: r1..r4 drain in order over 4 cycles.
- With wb_busy=1, push r7=0x10 then r7=0x20 and r9=0x30: q_addr1=7 gives hit1=1, hdata1=0x20; q_addr2=9 gives hdata2=0x30; q_addr1=0 gives hit1=0.
- Push r0=0xDEAD: handshake completes, count stays 0, rf_wr never asserts for it.
- Full queue with wb_busy=0 and in_valid held: one drain per cycle; a new accept occurs only on cycles where full=0; ordering is preserved with no lost or duplicated writes.
- Assert reset low mid-cycle with 3 entries buffered: rf_wr, hit1 and hit2 drop immediately, count=0; after release, no stale entry is ever written.
